// File: rtl/long_divider_fsm_if.sv
`default_nettype none
// ============================================================================
// long_divider_fsm_if : start/done handshake and data bus of the divider
// Rev 1.0 - initial release
// ============================================================================
interface long_divider_fsm_if;
  logic       start;
  logic [6:0] D;
  logic [3:0] M;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       overflow;

  modport master (
    output start, D, M,
    input  Q, R, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, D, M,
    output Q, R, busy, done, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/long_divider_fsm.sv
`default_nettype none
// ============================================================================
// long_divider_fsm : 7-bit / 4-bit unsigned restoring divider, one bit/clock
// Rev 1.0 - initial release
// ============================================================================
module long_divider_fsm (
  input  wire logic         clk,
  input  wire logic         rst,
  long_divider_fsm_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;
  logic [6:0] dvd;
  logic [3:0] dvs;
  logic [6:0] quo;
  // Partial remainder is always < divisor, so its top bit is never stored.
  logic [3:0] rem;
  logic [2:0] cnt;

  logic [4:0] trial;
  logic       take;
  logic [3:0] rem_next;
  logic [6:0] quo_next;

  always_comb begin
    trial    = {rem, dvd[cnt]};
    take     = (trial >= {1'b0, dvs});
    rem_next = take ? 4'(trial - {1'b0, dvs}) : trial[3:0];
    quo_next = quo;
    quo_next[cnt] = take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      dvd             <= '0;
      dvs             <= '0;
      quo             <= '0;
      rem             <= '0;
      cnt             <= '0;
      bus.Q           <= '0;
      bus.R           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            dvd <= bus.D;
            dvs <= bus.M;
            quo <= '0;
            rem <= '0;
            cnt <= 3'd6;
            if (bus.M == 4'd0) begin
              // Divide by zero skips RUN and reports immediately.
              state           <= S_DONE;
              bus.done        <= 1'b1;
              bus.Q           <= 4'hF;
              bus.R           <= bus.D[3:0];
              bus.div_by_zero <= 1'b1;
              bus.overflow    <= 1'b0;
            end else begin
              state    <= S_RUN;
              bus.busy <= 1'b1;
            end
          end
        end
        S_RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == 3'd0) begin
            state           <= S_DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.Q           <= quo_next[3:0];
            bus.R           <= rem_next;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= |quo_next[6:4];
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_long_divider_fsm.sv
`default_nettype none
// ============================================================================
// tb_long_divider_fsm : directed self-checking bench for long_divider_fsm
// Rev 1.0 - initial release
// ============================================================================
module tb_long_divider_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  long_divider_fsm_if bus ();

  long_divider_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Index n counts negedges after the start edge; index n samples what edge n sees.
  task automatic run_div(input string tag, input logic [6:0] d, input logic [3:0] m,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic edbz, input logic eovf,
                         input int elat, input int ebusy, input bit inject);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    bus.D = d;
    bus.M = m;
    bus.start = 1'b1;
    for (int idx = 1; idx <= 20 && lat == 0; idx++) begin
      @(negedge clk);
      if (idx == 1) bus.start = 1'b0;
      if (inject && idx == 3) begin
        bus.start = 1'b1; bus.D = 7'd9; bus.M = 4'd4;
      end
      if (inject && idx == 4) begin
        bus.start = 1'b0; bus.D = 7'd120; bus.M = 4'd3;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) lat = idx;
    end
    check({tag, "_latency"}, 8'(lat), 8'(elat));
    check({tag, "_busy_cycles"}, 8'(busy_cnt), 8'(ebusy));
    check({tag, "_Q"}, {4'h0, bus.Q}, {4'h0, eq});
    check({tag, "_R"}, {4'h0, bus.R}, {4'h0, er});
    check({tag, "_dbz"}, {7'h0, bus.div_by_zero}, {7'h0, edbz});
    check({tag, "_ovf"}, {7'h0, bus.overflow}, {7'h0, eovf});
    @(negedge clk);
    check({tag, "_done_pulse"}, {7'h0, bus.done}, 8'h00);
    check({tag, "_Q_hold"}, {4'h0, bus.Q}, {4'h0, eq});
  endtask

  initial begin
    int seen_done;
    int seen_busy;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.D = '0;
    bus.M = '0;
    repeat (2) @(negedge clk);
    check("rst_Q", {4'h0, bus.Q}, 8'h00);
    check("rst_R", {4'h0, bus.R}, 8'h00);
    check("rst_flags", {4'h0, bus.busy, bus.done, bus.div_by_zero, bus.overflow}, 8'h00);
    rst = 1'b0;

    run_div("d7m2",    7'd7,   4'd2, 4'd3,  4'd1, 1'b0, 1'b0, 8, 7, 1'b0);
    run_div("d6m2",    7'd6,   4'd2, 4'd3,  4'd0, 1'b0, 1'b0, 8, 7, 1'b0);
    run_div("d9m4",    7'd9,   4'd4, 4'd2,  4'd1, 1'b0, 1'b0, 8, 7, 1'b0);
    run_div("d12m5",   7'd12,  4'd5, 4'd2,  4'd2, 1'b0, 1'b0, 8, 7, 1'b0);
    run_div("d100m7",  7'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0, 8, 7, 1'b0);
    run_div("d127m1",  7'd127, 4'd1, 4'hF,  4'd0, 1'b0, 1'b1, 8, 7, 1'b0);
    run_div("d16m1",   7'd16,  4'd1, 4'd0,  4'd0, 1'b0, 1'b1, 8, 7, 1'b0);
    run_div("d13m0",   7'd13,  4'd0, 4'hF,  4'hD, 1'b1, 1'b0, 1, 0, 1'b0);
    run_div("ignore2", 7'd7,   4'd2, 4'd3,  4'd1, 1'b0, 1'b0, 8, 7, 1'b1);

    // Reset sampled at edge 4 of a running division.
    @(negedge clk);
    bus.D = 7'd100; bus.M = 4'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_Q", {4'h0, bus.Q}, 8'h00);
    check("abort_R", {4'h0, bus.R}, 8'h00);
    check("abort_flags", {4'h0, bus.busy, bus.done, bus.div_by_zero, bus.overflow}, 8'h00);
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
      if (bus.busy) seen_busy++;
    end
    check("abort_no_done", 8'(seen_done), 8'h00);
    check("abort_no_busy", 8'(seen_busy), 8'h00);
    run_div("after_abort", 7'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b0, 8, 7, 1'b0);

    // Start coincident with reset is dropped.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.D = 7'd9; bus.M = 4'd4;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
      if (bus.busy) seen_busy++;
    end
    check("rst_start_no_done", 8'(seen_done), 8'h00);
    check("rst_start_no_busy", 8'(seen_busy), 8'h00);
    check("rst_start_Q", {4'h0, bus.Q}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
